// File: rtl/block_ram_be.sv
// Simple dual-port byte-strobed block RAM with exact depth, 1/2-cycle read
// latency, selectable read-during-write policy and an optional zero-fill after reset.
module block_ram_be #(
  parameter int SIZE            = 4096,
  parameter int WIDTH           = 32,
  parameter int READ_LATENCY    = 1,
  parameter int RDW_WRITE_FIRST = 0,
  parameter int CLEAR_ON_RESET  = 1,
  localparam int LANES = WIDTH / 8,
  localparam int DEPTH = SIZE / LANES,
  localparam int AW    = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic             clk,
  input  logic             reset,
  output logic             ready,
  input  logic             write_en,
  input  logic [LANES-1:0] write_strobe,
  input  logic [AW-1:0]    write_address,
  input  logic [WIDTH-1:0] write_data,
  input  logic             read_en,
  input  logic [AW-1:0]    read_address,
  output logic [WIDTH-1:0] read_data,
  output logic             read_valid
);

  if ((WIDTH % 8) != 0 || WIDTH < 8) begin : g_bad_width
    $error("block_ram_be: WIDTH must be a multiple of 8 and at least 8");
  end
  if ((SIZE % LANES) != 0) begin : g_bad_size
    $error("block_ram_be: SIZE must be a whole number of words");
  end
  if (READ_LATENCY != 1 && READ_LATENCY != 2) begin : g_bad_latency
    $error("block_ram_be: READ_LATENCY must be 1 or 2");
  end

  localparam logic [AW:0]   DEPTH_W   = (AW + 1)'(DEPTH);
  localparam logic [AW-1:0] LAST_ADDR = AW'(DEPTH - 1);

  typedef enum logic [0:0] {
    ST_CLEAR = 1'b0,
    ST_READY = 1'b1
  } state_t;

  localparam state_t RESET_STATE = (CLEAR_ON_RESET != 0) ? ST_CLEAR : ST_READY;

  state_t           state_q;
  state_t           state_d;
  logic [AW-1:0]    clear_ptr;
  logic [WIDTH-1:0] mem [DEPTH];

  logic             clearing;
  logic             wr_in_range;
  logic             rd_in_range;
  logic             wr_accept;
  logic             rd_accept;
  logic [WIDTH-1:0] rd_word;

  // Handshake: a request is taken on any rising edge where ready is high and
  // its enable is set; there is no backpressure, and every taken read yields
  // exactly one read_valid pulse, in request order, READ_LATENCY edges later.
  assign ready       = (state_q == ST_READY);
  assign clearing    = (state_q == ST_CLEAR) && !reset;
  assign wr_in_range = ({1'b0, write_address} < DEPTH_W);
  assign rd_in_range = ({1'b0, read_address} < DEPTH_W);
  assign wr_accept   = ready && !reset && write_en && wr_in_range;
  assign rd_accept   = ready && !reset && read_en;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= RESET_STATE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    if (state_q == ST_CLEAR && clear_ptr == LAST_ADDR) begin
      state_d = ST_READY;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      clear_ptr <= '0;
    end else if (state_q == ST_CLEAR) begin
      clear_ptr <= clear_ptr + AW'(1);
    end
  end

  // Storage carries no reset; only the clear sequence and writes touch it.
  always_ff @(posedge clk) begin
    if (clearing) begin
      mem[clear_ptr] <= '0;
    end else if (wr_accept) begin
      for (int i = 0; i < LANES; i++) begin
        if (write_strobe[i]) begin
          mem[write_address][8*i +: 8] <= write_data[8*i +: 8];
        end
      end
    end
  end

  always_comb begin
    rd_word = '0;
    if (rd_in_range) begin
      rd_word = mem[read_address];
      if (RDW_WRITE_FIRST != 0 && write_en && write_address == read_address) begin
        for (int i = 0; i < LANES; i++) begin
          if (write_strobe[i]) begin
            rd_word[8*i +: 8] = write_data[8*i +: 8];
          end
        end
      end
    end
  end

  if (READ_LATENCY == 1) begin : g_lat1
    always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
        read_valid <= 1'b0;
        read_data  <= '0;
      end else begin
        read_valid <= rd_accept;
        if (rd_accept) begin
          read_data <= rd_word;
        end
      end
    end
  end else begin : g_lat2
    logic             pipe_valid;
    logic [WIDTH-1:0] pipe_data;

    always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
        pipe_valid <= 1'b0;
        pipe_data  <= '0;
        read_valid <= 1'b0;
        read_data  <= '0;
      end else begin
        pipe_valid <= rd_accept;
        if (rd_accept) begin
          pipe_data <= rd_word;
        end
        read_valid <= pipe_valid;
        if (pipe_valid) begin
          read_data <= pipe_data;
        end
      end
    end
  end

endmodule

// File: tb/tb_block_ram_be.sv
// Bench for block_ram_be: three configurations share one stimulus stream and are
// compared every cycle against a per-configuration behavioural memory model.
module tb_block_ram_be;

  localparam int SIZE  = 40;
  localparam int W     = 32;
  localparam int DEPTH = 10;
  localparam int AW    = 4;
  localparam int NDUT  = 3;

  typedef struct packed {
    logic [31:0]  due;
    logic         known;
    logic [W-1:0] data;
  } rd_t;

  // clock / reset
  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  logic          write_en = 1'b0;
  logic [3:0]    write_strobe = '0;
  logic [AW-1:0] write_address = '0;
  logic [W-1:0]  write_data = '0;
  logic          read_en = 1'b0;
  logic [AW-1:0] read_address = '0;

  logic         rdy [NDUT];
  logic         rv  [NDUT];
  logic [W-1:0] rd  [NDUT];

  block_ram_be #(.SIZE(SIZE), .WIDTH(W), .READ_LATENCY(1), .RDW_WRITE_FIRST(0), .CLEAR_ON_RESET(1)) u_a (
    .clk(clk), .reset(reset), .ready(rdy[0]), .write_en(write_en), .write_strobe(write_strobe),
    .write_address(write_address), .write_data(write_data), .read_en(read_en),
    .read_address(read_address), .read_data(rd[0]), .read_valid(rv[0]));

  block_ram_be #(.SIZE(SIZE), .WIDTH(W), .READ_LATENCY(2), .RDW_WRITE_FIRST(1), .CLEAR_ON_RESET(1)) u_b (
    .clk(clk), .reset(reset), .ready(rdy[1]), .write_en(write_en), .write_strobe(write_strobe),
    .write_address(write_address), .write_data(write_data), .read_en(read_en),
    .read_address(read_address), .read_data(rd[1]), .read_valid(rv[1]));

  block_ram_be #(.SIZE(SIZE), .WIDTH(W), .READ_LATENCY(2), .RDW_WRITE_FIRST(0), .CLEAR_ON_RESET(0)) u_c (
    .clk(clk), .reset(reset), .ready(rdy[2]), .write_en(write_en), .write_strobe(write_strobe),
    .write_address(write_address), .write_data(write_data), .read_en(read_en),
    .read_address(read_address), .read_data(rd[2]), .read_valid(rv[2]));

  int lat [NDUT] = '{1, 2, 2};
  int rdw [NDUT] = '{0, 1, 0};
  int clr [NDUT] = '{1, 1, 0};

  // scoreboard bookkeeping
  int pass_cnt  = 0;
  int total_cnt = 0;

  task automatic chk(input string name, input logic [W-1:0] got, input logic [W-1:0] exp);
    total_cnt++;
    if (got === exp) pass_cnt++;
    else $display("FAIL %s: got %h expected %h", name, got, exp);
  endtask

  // behavioural model: memory image, known flags, clear progress, expected read queue
  logic [W-1:0] mm [NDUT][DEPTH];
  bit           mk [NDUT][DEPTH];
  bit           m_ready [NDUT];
  int           m_cnt [NDUT];
  rd_t          exp_q [NDUT][$];
  bit           exp_valid [NDUT];
  logic [W-1:0] exp_data [NDUT];
  bit           exp_known [NDUT];
  int           cyc = 0;
  bit           cmp_on = 1'b1;

  initial begin
    for (int d = 0; d < NDUT; d++) begin
      for (int i = 0; i < DEPTH; i++) begin
        mm[d][i] = '0;
        mk[d][i] = 1'b0;
      end
    end
  end

  always @(posedge clk) begin
    rd_t ent;
    for (int d = 0; d < NDUT; d++) begin
      if (reset) begin
        exp_q[d].delete();
        m_ready[d]   = (clr[d] == 0);
        m_cnt[d]     = 0;
        exp_valid[d] = 1'b0;
        exp_data[d]  = '0;
        exp_known[d] = 1'b1;
      end else begin
        if (!m_ready[d]) begin
          mm[d][m_cnt[d]] = '0;
          mk[d][m_cnt[d]] = 1'b1;
          m_cnt[d]++;
          if (m_cnt[d] == DEPTH) m_ready[d] = 1'b1;
        end else begin
          if (read_en) begin
            ent.due   = cyc + lat[d] - 1;
            ent.data  = '0;
            ent.known = 1'b1;
            if (int'(read_address) < DEPTH) begin
              ent.data  = mm[d][read_address];
              ent.known = mk[d][read_address];
              if (rdw[d] != 0 && write_en && write_address == read_address) begin
                for (int i = 0; i < 4; i++)
                  if (write_strobe[i]) ent.data[8*i +: 8] = write_data[8*i +: 8];
                ent.known = ent.known || (write_strobe == 4'hF);
              end
            end
            exp_q[d].push_back(ent);
          end
          if (write_en && int'(write_address) < DEPTH) begin
            for (int i = 0; i < 4; i++)
              if (write_strobe[i]) mm[d][write_address][8*i +: 8] = write_data[8*i +: 8];
            if (write_strobe == 4'hF) mk[d][write_address] = 1'b1;
          end
        end
        if (exp_q[d].size() > 0 && exp_q[d][0].due == cyc) begin
          ent = exp_q[d].pop_front();
          exp_valid[d] = 1'b1;
          exp_data[d]  = ent.data;
          exp_known[d] = ent.known;
        end else begin
          exp_valid[d] = 1'b0;
        end
      end
    end
    cyc++;
  end

  // compare process: every cycle, away from the active edge
  initial begin
    forever begin
      @(posedge clk);
      #2;
      if (cmp_on) begin
        for (int d = 0; d < NDUT; d++) begin
          chk($sformatf("ready[%0d]", d), {31'b0, rdy[d]}, {31'b0, m_ready[d]});
          chk($sformatf("read_valid[%0d]", d), {31'b0, rv[d]}, {31'b0, exp_valid[d]});
          if (exp_known[d]) chk($sformatf("read_data[%0d]", d), rd[d], exp_data[d]);
        end
      end
    end
  end

  // driver tasks
  task automatic step(input bit we, input logic [3:0] ws, input logic [AW-1:0] wa,
                      input logic [W-1:0] wd, input bit re, input logic [AW-1:0] ra);
    @(negedge clk);
    write_en = we; write_strobe = ws; write_address = wa; write_data = wd;
    read_en = re; read_address = ra;
  endtask

  task automatic idle();
    step(1'b0, 4'h0, '0, '0, 1'b0, '0);
  endtask

  task automatic do_reset();
    @(negedge clk);
    write_en = 1'b0; read_en = 1'b0; write_strobe = '0;
    reset = 1'b1;
    #1;
    for (int d = 0; d < NDUT; d++) begin
      chk($sformatf("rst_valid[%0d]", d), {31'b0, rv[d]}, 32'd0);
      chk($sformatf("rst_data[%0d]", d), rd[d], 32'd0);
    end
    repeat (2) @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic wait_ready(input string name);
    int first;
    first = 0;
    for (int k = 1; k <= 20; k++) begin
      idle();
      if (first == 0 && rdy[0] && rdy[1]) first = k;
    end
    chk(name, first, 32'd10);
  endtask

  int first_rdy, early_valid, nvalid, bad, first_v, last_v;

  initial begin
    // phase 0: initial clear, then fill every word with ones
    repeat (3) @(negedge clk);
    reset = 1'b0;
    wait_ready("init_ready_edges");
    for (int i = 0; i < DEPTH; i++) step(1'b1, 4'hF, AW'(i), 32'hFFFF_FFFF, 1'b0, '0);

    // test 1: clear after reset while read_en is held high
    do_reset();
    read_en = 1'b1; read_address = '0;
    first_rdy = 0; early_valid = 0; nvalid = 0; bad = 0;
    for (int k = 1; k <= 20; k++) begin
      @(negedge clk);
      if (first_rdy == 0 && rdy[0]) first_rdy = k;
      if ((!rdy[0] && rv[0]) || (!rdy[1] && rv[1])) early_valid++;
      if (rdy[0] && rv[0]) begin
        nvalid++;
        if (rd[0] !== 32'd0) bad++;
      end
      read_address = AW'(k % 10);
    end
    chk("t1_ready_edges", first_rdy, 32'd10);
    chk("t1_no_early_valid", early_valid, 32'd0);
    chk("t1_valid_count", nvalid, 32'd10);
    chk("t1_zero_data", bad, 32'd0);
    idle();
    idle();

    // test 3: same-address read and write on one edge
    step(1'b1, 4'b0011, 4'd5, 32'hDEAD_BEEF, 1'b1, 4'd5);
    idle();
    chk("t3_rf_valid", {31'b0, rv[0]}, 32'd1);
    chk("t3_read_first", rd[0], 32'h0000_0000);
    idle();
    chk("t3_wf_valid", {31'b0, rv[1]}, 32'd1);
    chk("t3_write_first", rd[1], 32'h0000_BEEF);
    step(1'b0, 4'h0, '0, '0, 1'b1, 4'd5);
    idle();
    chk("t3_reread_a", rd[0], 32'h0000_BEEF);
    idle();
    chk("t3_reread_b", rd[1], 32'h0000_BEEF);

    // test 2: byte strobes and read latency
    step(1'b1, 4'b1111, 4'd3, 32'hAABB_CCDD, 1'b0, '0);
    step(1'b1, 4'b0101, 4'd3, 32'h1122_3344, 1'b0, '0);
    step(1'b0, 4'h0, '0, '0, 1'b1, 4'd3);
    idle();
    chk("t2_lat1_valid", {31'b0, rv[0]}, 32'd1);
    chk("t2_lat1_data", rd[0], 32'hAA22_CC44);
    chk("t2_lat2_early", {31'b0, rv[1]}, 32'd0);
    idle();
    chk("t2_lat2_valid", {31'b0, rv[1]}, 32'd1);
    chk("t2_lat2_data", rd[1], 32'hAA22_CC44);
    chk("t2_lat1_pulse", {31'b0, rv[0]}, 32'd0);
    chk("t2_lat1_hold", rd[0], 32'hAA22_CC44);

    // test 4: streamed reads at latency 2
    for (int i = 0; i < DEPTH; i++) step(1'b1, 4'hF, AW'(i), 32'h100 + i, 1'b0, '0);
    nvalid = 0; bad = 0; first_v = -1; last_v = -1;
    for (int k = 0; k < 12; k++) begin
      if (k < 8) step(1'b0, 4'h0, '0, '0, 1'b1, AW'(k));
      else idle();
      if (rv[1]) begin
        if (rd[1] !== 32'h100 + nvalid) bad++;
        if (first_v < 0) first_v = k;
        last_v = k;
        nvalid++;
      end
    end
    chk("t4_pulses", nvalid, 32'd8);
    chk("t4_consecutive", last_v - first_v, 32'd7);
    chk("t4_order_data", bad, 32'd0);
    chk("t4_hold_data", rd[1], 32'h107);
    chk("t4_hold_valid", {31'b0, rv[1]}, 32'd0);

    // test 5: out-of-range write and read
    step(1'b1, 4'hF, 4'd10, 32'h1234_5678, 1'b0, '0);
    step(1'b1, 4'hF, 4'd15, 32'h8765_4321, 1'b0, '0);
    step(1'b0, 4'h0, '0, '0, 1'b1, 4'd12);
    idle();
    chk("t5_oor_valid_a", {31'b0, rv[0]}, 32'd1);
    chk("t5_oor_data_a", rd[0], 32'd0);
    idle();
    chk("t5_oor_valid_b", {31'b0, rv[1]}, 32'd1);
    chk("t5_oor_data_b", rd[1], 32'd0);
    for (int i = 0; i < DEPTH; i++) chk($sformatf("t5_mem[%0d]", i), u_a.mem[i], 32'h100 + i);

    // randomized traffic
    for (int k = 0; k < 300; k++) begin
      step($urandom_range(0, 1), 4'($urandom_range(0, 15)), AW'($urandom_range(0, 11)), $urandom,
           $urandom_range(0, 1), AW'($urandom_range(0, 11)));
    end
    idle();

    // test 6a: reset in the middle of the clear sequence
    do_reset();
    repeat (6) idle();
    chk("t6_clear_ptr", {28'b0, u_a.clear_ptr}, 32'd6);
    do_reset();
    wait_ready("t6_restart_ready_edges");
    for (int i = 0; i < DEPTH; i++) begin
      chk($sformatf("t6_mem_a[%0d]", i), u_a.mem[i], 32'd0);
      chk($sformatf("t6_mem_b[%0d]", i), u_b.mem[i], 32'd0);
    end

    for (int k = 0; k < 100; k++) begin
      step($urandom_range(0, 1), 4'($urandom_range(0, 15)), AW'($urandom_range(0, 11)), $urandom,
           $urandom_range(0, 1), AW'($urandom_range(0, 11)));
    end

    // test 6b: reset with reads in flight
    step(1'b0, 4'h0, '0, '0, 1'b1, 4'd1);
    step(1'b0, 4'h0, '0, '0, 1'b1, 4'd2);
    do_reset();
    nvalid = 0;
    for (int k = 0; k < 14; k++) begin
      idle();
      if (rv[0] || rv[1] || rv[2]) nvalid++;
    end
    chk("t6_flushed_reads", nvalid, 32'd0);
    repeat (3) idle();

    cmp_on = 1'b0;
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
